// File: rtl/lcd_msg_arbiter_if.sv
// Bus between the LCD message requesters and the arbiter.
// Ports: init flag, per-requester request levels and packed 8-bit message codes in;
//        one-hot ack/done pulses, abort pulse, displayed message, owner index and busy out.
interface lcd_msg_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic                   i_finish_init;
    logic [NUM_REQ-1:0]     i_req;
    logic [8*NUM_REQ-1:0]   i_msg;
    logic [NUM_REQ-1:0]     o_ack;
    logic [NUM_REQ-1:0]     o_done;
    logic                   o_abort;
    logic [7:0]             o_message;
    logic [2:0]             o_owner;
    logic                   o_busy;

    // Requester / controller side.
    modport master (
        output i_finish_init, i_req, i_msg,
        input  o_ack, o_done, o_abort, o_message, o_owner, o_busy
    );

    // Arbiter side.
    modport slave (
        input  i_finish_init, i_req, i_msg,
        output o_ack, o_done, o_abort, o_message, o_owner, o_busy
    );
endinterface

// File: rtl/lcd_msg_arbiter.sv
// Shares the LCD message channel among NUM_REQ requesters; each grant is held HOLD_CYCLES cycles.
// Ports: i_clk, i_rst (async, active-high), bus (slave modport: requests/messages in,
//        ack/done/abort pulses, displayed message, owner and busy out). All outputs registered.
module lcd_msg_arbiter #(
    parameter int         NUM_REQ     = 4,
    parameter int         HOLD_CYCLES = 800000,
    parameter logic [7:0] IDLE_MSG    = 8'h00,
    parameter logic [7:0] CLEAR_MSG   = 8'hFF,
    parameter bit         PRIO0       = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    lcd_msg_arbiter_if.slave bus
);

    localparam logic [1:0] S_WAIT_INIT = 2'd0;
    localparam logic [1:0] S_IDLE      = 2'd1;
    localparam logic [1:0] S_HOLD      = 2'd2;

    localparam int CW = $clog2(HOLD_CYCLES);

    logic [1:0]    state;
    logic [CW-1:0] hold_cnt;
    logic [2:0]    rr_ptr;

    logic          any_req;
    logic          found;
    logic [2:0]    winner;
    logic [7:0]    win_msg;
    logic          hold_last;

    // Arbitration: requester 0 may pre-empt the rotation; otherwise scan
    // upward from the last winner, so the previous owner ranks last.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        winner  = '0;
        any_req = |bus.i_req;
        if (PRIO0 && bus.i_req[0]) begin
            found  = 1'b1;
            winner = '0;
        end
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && bus.i_req[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
        win_msg = bus.i_msg[8*int'(winner) +: 8];
    end

    assign hold_last = (state == S_HOLD) && (hold_cnt == CW'(HOLD_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_WAIT_INIT;
            hold_cnt      <= '0;
            rr_ptr        <= 3'(NUM_REQ - 1);
            bus.o_message <= CLEAR_MSG;
            bus.o_ack     <= '0;
            bus.o_done    <= '0;
            bus.o_abort   <= 1'b0;
            bus.o_busy    <= 1'b0;
            bus.o_owner   <= '0;
        end else begin
            bus.o_ack   <= '0;
            bus.o_done  <= '0;
            bus.o_abort <= 1'b0;

            if (state != S_IDLE && state != S_HOLD) begin
                // Waiting for the controller; requests are ignored here.
                bus.o_message <= CLEAR_MSG;
                bus.o_busy    <= 1'b0;
                hold_cnt      <= '0;
                if (bus.i_finish_init) begin
                    state         <= S_IDLE;
                    bus.o_message <= IDLE_MSG;
                end
            end else if (!bus.i_finish_init) begin
                // Init loss wins over a hold ending in the same cycle; pointer is kept.
                state         <= S_WAIT_INIT;
                bus.o_message <= CLEAR_MSG;
                bus.o_busy    <= 1'b0;
                bus.o_abort   <= (state == S_HOLD);
                hold_cnt      <= '0;
            end else if (state == S_IDLE || hold_last) begin
                if (state == S_HOLD) begin
                    bus.o_done <= NUM_REQ'(1) << bus.o_owner;
                end
                if (any_req) begin
                    // Back-to-back grant: ack lands in the same cycle as done.
                    state         <= S_HOLD;
                    bus.o_message <= win_msg;
                    bus.o_owner   <= winner;
                    bus.o_busy    <= 1'b1;
                    bus.o_ack     <= NUM_REQ'(1) << winner;
                    hold_cnt      <= '0;
                    rr_ptr        <= winner;
                end else begin
                    state         <= S_IDLE;
                    bus.o_message <= IDLE_MSG;
                    bus.o_busy    <= 1'b0;
                    hold_cnt      <= '0;
                end
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
module tb_lcd_msg_arbiter;
    localparam int N = 4;
    localparam int H = 4;

    logic        clk;
    logic        rst;
    logic        init_v [2];
    logic [3:0]  req_v  [2];
    logic [31:0] msg_v  [2];

    logic [3:0]  ack_v  [2];
    logic [3:0]  done_v [2];
    logic        abort_v[2];
    logic        busy_v [2];
    logic [7:0]  mesg_v [2];
    logic [2:0]  own_v  [2];

    int checks = 0;
    int errors = 0;

    lcd_msg_arbiter_if #(.NUM_REQ(N)) bus_a ();
    lcd_msg_arbiter_if #(.NUM_REQ(N)) bus_b ();

    assign bus_a.i_finish_init = init_v[0];
    assign bus_a.i_req         = req_v[0];
    assign bus_a.i_msg         = msg_v[0];
    assign bus_b.i_finish_init = init_v[1];
    assign bus_b.i_req         = req_v[1];
    assign bus_b.i_msg         = msg_v[1];

    assign ack_v[0]   = bus_a.o_ack;
    assign done_v[0]  = bus_a.o_done;
    assign abort_v[0] = bus_a.o_abort;
    assign busy_v[0]  = bus_a.o_busy;
    assign mesg_v[0]  = bus_a.o_message;
    assign own_v[0]   = bus_a.o_owner;
    assign ack_v[1]   = bus_b.o_ack;
    assign done_v[1]  = bus_b.o_done;
    assign abort_v[1] = bus_b.o_abort;
    assign busy_v[1]  = bus_b.o_busy;
    assign mesg_v[1]  = bus_b.o_message;
    assign own_v[1]   = bus_b.o_owner;

    lcd_msg_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H), .IDLE_MSG(8'h00),
                      .CLEAR_MSG(8'hFF), .PRIO0(1'b1)) u_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a));

    lcd_msg_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H), .IDLE_MSG(8'h00),
                      .CLEAR_MSG(8'hFF), .PRIO0(1'b0)) u_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = controller not ready, 1 = nothing shown, 2 = showing a message
    int         m_phase[2];
    int         m_left [2];   // cycles of display still owed to the current owner
    int         m_owner[2];
    int         m_ptr  [2];   // most recent winner
    int         prio_v [2];
    logic [3:0] e_ack  [2];
    logic [3:0] e_done [2];
    logic       e_abort[2];
    logic       e_busy [2];
    logic [7:0] e_msg  [2];
    logic [2:0] e_owner[2];

    function automatic int pick(input int d, input logic [3:0] r);
        if (prio_v[d] == 1 && r[0]) return 0;
        for (int off = 1; off <= N; off++) begin
            if (r[(m_ptr[d] + off) % N]) return (m_ptr[d] + off) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0; m_left[d] = 0; m_owner[d] = 0; m_ptr[d] = N - 1;
            e_ack[d] = '0; e_done[d] = '0; e_abort[d] = 1'b0; e_busy[d] = 1'b0;
            e_msg[d] = 8'hFF; e_owner[d] = '0;
        end
    endtask

    task automatic model_grant(input int d);
        int w;
        w = pick(d, req_v[d]);
        e_ack[d]   = 4'(1 << w);
        e_msg[d]   = msg_v[d][8*w +: 8];
        e_owner[d] = 3'(w);
        e_busy[d]  = 1'b1;
        m_owner[d] = w;
        m_ptr[d]   = w;
        m_left[d]  = H;
        m_phase[d] = 2;
    endtask

    task automatic model_step(input int d);
        e_ack[d] = '0; e_done[d] = '0; e_abort[d] = 1'b0;
        if (m_phase[d] == 0) begin
            if (init_v[d]) begin
                m_phase[d] = 1;
                e_msg[d]   = 8'h00;
            end
        end else if (!init_v[d]) begin
            e_abort[d] = (m_phase[d] == 2);
            m_phase[d] = 0;
            e_busy[d]  = 1'b0;
            e_msg[d]   = 8'hFF;
        end else if (m_phase[d] == 1) begin
            if (req_v[d] != 0) model_grant(d);
        end else begin
            m_left[d] = m_left[d] - 1;
            if (m_left[d] == 0) begin
                e_done[d] = 4'(1 << m_owner[d]);
                if (req_v[d] != 0) model_grant(d);
                else begin
                    m_phase[d] = 1;
                    e_busy[d]  = 1'b0;
                    e_msg[d]   = 8'h00;
                end
            end
        end
    endtask

    initial begin
        prio_v[0] = 1;
        prio_v[1] = 0;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ack%0d", d),     32'(ack_v[d]),   32'(e_ack[d]));
            chk($sformatf("done%0d", d),    32'(done_v[d]),  32'(e_done[d]));
            chk($sformatf("abort%0d", d),   32'(abort_v[d]), 32'(e_abort[d]));
            chk($sformatf("busy%0d", d),    32'(busy_v[d]),  32'(e_busy[d]));
            chk($sformatf("message%0d", d), 32'(mesg_v[d]),  32'(e_msg[d]));
            if (e_busy[d]) chk($sformatf("owner%0d", d), 32'(own_v[d]), 32'(e_owner[d]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ack(input int d, input int budget, input logic [3:0] exp, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack_v[d] != 0) break;
        end
        chk(name, 32'(ack_v[d]), 32'(exp));
    endtask

    task automatic wait_idle(input int d, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy_v[d]) break;
        end
        chk(name, 32'(busy_v[d]), 32'd0);
    endtask

    logic saw;

    initial begin
        rst = 1'b1;
        init_v[0] = 1'b0; init_v[1] = 1'b0;
        req_v[0] = '0;    req_v[1] = '0;
        msg_v[0] = {8'h44, 8'h33, 8'h22, 8'h11};
        msg_v[1] = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        repeat (3) @(negedge clk);
        chk("reset_message", 32'(mesg_v[0]), 32'hFF);
        chk("reset_busy", 32'(busy_v[0]), 32'd0);
        rst = 1'b0;

        // 1: requests ignored until init, then requester 0 wins
        req_v[0] = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("uninit_message", 32'(mesg_v[0]), 32'hFF);
            chk("uninit_ack", 32'(ack_v[0]), 32'd0);
        end
        init_v[0] = 1'b1;
        init_v[1] = 1'b1;
        @(negedge clk);
        chk("init_idle_message", 32'(mesg_v[0]), 32'h00);
        @(negedge clk);
        chk("first_grant_ack", 32'(ack_v[0]), 32'b0001);
        chk("first_grant_message", 32'(mesg_v[0]), 32'h11);
        req_v[0] = '0;
        wait_idle(0, 8, "s1_idle");

        // 2: single request from requester 2
        @(negedge clk);
        msg_v[0][23:16] = 8'h12;
        req_v[0] = 4'b0100;
        @(negedge clk);
        chk("s2_ack", 32'(ack_v[0]), 32'b0100);
        req_v[0] = '0;
        for (int k = 1; k < H; k++) begin
            @(negedge clk);
            chk("s2_hold_message", 32'(mesg_v[0]), 32'h12);
        end
        @(negedge clk);
        chk("s2_done", 32'(done_v[0]), 32'b0100);
        chk("s2_idle_message", 32'(mesg_v[0]), 32'h00);

        // 3: pure round-robin instance, permanent requests 1..3
        req_v[1] = 4'b1110;
        wait_ack(1, 6, 4'b0010, "s3_first_ack");
        begin
            logic [3:0] seq [3];
            logic [3:0] prev;
            seq[0] = 4'b0100; seq[1] = 4'b1000; seq[2] = 4'b0010;
            prev = 4'b0010;
            for (int g = 0; g < 3; g++) begin
                repeat (H) @(negedge clk);
                chk("s3_rr_ack", 32'(ack_v[1]), 32'(seq[g]));
                chk("s3_rr_done", 32'(done_v[1]), 32'(prev));
                prev = seq[g];
            end
            chk("s3_message", 32'(mesg_v[1]), 32'hB1);
        end
        req_v[1] = '0;
        wait_idle(1, 8, "s3_idle");

        // 4: priority-0 pre-emption of the rotation, then rotation resumes
        msg_v[0] = {8'h33, 8'h12, 8'h22, 8'h11};
        req_v[0] = 4'b1000;
        wait_ack(0, 4, 4'b1000, "s4_ack3");
        req_v[0] = 4'b0011;
        repeat (H) @(negedge clk);
        chk("s4_ack0", 32'(ack_v[0]), 32'b0001);
        chk("s4_done3", 32'(done_v[0]), 32'b1000);
        req_v[0] = 4'b0010;
        repeat (H) @(negedge clk);
        chk("s4_ack1", 32'(ack_v[0]), 32'b0010);
        chk("s4_done0", 32'(done_v[0]), 32'b0001);
        req_v[0] = '0;
        wait_idle(0, 8, "s4_idle");

        // 5: init lost in the second hold cycle
        msg_v[0][23:16] = 8'h55;
        req_v[0] = 4'b0100;
        wait_ack(0, 4, 4'b0100, "s5_ack");
        req_v[0] = '0;
        @(negedge clk);
        init_v[0] = 1'b0;
        @(negedge clk);
        chk("s5_abort", 32'(abort_v[0]), 32'd1);
        chk("s5_clear", 32'(mesg_v[0]), 32'hFF);
        chk("s5_busy", 32'(busy_v[0]), 32'd0);
        chk("s5_no_done", 32'(done_v[0]), 32'd0);
        init_v[0] = 1'b1;
        req_v[0]  = 4'b1010;
        @(negedge clk);
        chk("s5_idle_message", 32'(mesg_v[0]), 32'h00);
        @(negedge clk);
        chk("s5_ptr_kept_ack", 32'(ack_v[0]), 32'b1000);
        req_v[0] = '0;
        wait_idle(0, 8, "s5_idle");

        // 6: reset in the third hold cycle
        msg_v[0][15:8] = 8'h77;
        req_v[0] = 4'b0010;
        wait_ack(0, 4, 4'b0010, "s6_ack");
        req_v[0] = '0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_message", 32'(mesg_v[0]), 32'hFF);
        chk("s6_rst_busy", 32'(busy_v[0]), 32'd0);
        chk("s6_rst_owner", 32'(own_v[0]), 32'd0);
        chk("s6_rst_ack", 32'(ack_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_v[0] != 0 || done_v[0] != 0 || abort_v[0]) saw = 1'b1;
        end
        chk("s6_no_pulse_after_reset", 32'(saw), 32'd0);
        req_v[0] = 4'b1010;
        wait_ack(0, 4, 4'b0010, "s6_ptr_reset_ack");
        req_v[0] = '0;
        wait_idle(0, 8, "s6_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
